// File: rtl/hid_keycode_source_pkg.sv
// Shared types and constants for the HID keycode source.
// Feature macro KEY_TIMEOUT_EN is consumed by hid_keycode_source.
package hid_pkg;

  typedef enum logic [2:0] {
    ST_MOD,
    ST_RSV,
    ST_KEYS,
    ST_COMMIT,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] KC_NONE     = 8'h00;
  localparam logic [7:0] KC_ROLLOVER = 8'h01;

  // Keycodes the motion/camera consumer acts on
  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_Q     = 8'h14;
  localparam logic [7:0] KC_E     = 8'h08;
  localparam logic [7:0] KC_UP    = 8'h52;
  localparam logic [7:0] KC_DOWN  = 8'h51;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_Z     = 8'h1D;
  localparam logic [7:0] KC_X     = 8'h1B;

  localparam int NKEYS_DEF = 6;
  localparam int RPT_LEN   = NKEYS_DEF + 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hid_keycode_source_if.sv
// Report byte stream: producer drives data/valid/last, consumer returns ready.
interface hid_keycode_source_if;
  logic [7:0] rpt_data;
  logic       rpt_valid;
  logic       rpt_last;
  logic       rpt_ready;

  modport master (output rpt_data, output rpt_valid, output rpt_last, input rpt_ready);
  modport slave  (input rpt_data, input rpt_valid, input rpt_last, output rpt_ready);
endinterface

// File: rtl/hid_key_select.sv
// Combinational keycode pick over the report slots: ErrorRollOver wins,
// otherwise the lowest-index nonzero slot.
module hid_key_select
  import hid_pkg::*;
#(
  parameter int NKEYS = 6
) (
  input  logic [NKEYS-1:0][7:0] slots,
  output logic [7:0]            key,
  output logic                  roll
);

  logic [NKEYS-1:0] is_roll;
  logic [NKEYS-1:0] is_key;

  for (genvar i = 0; i < NKEYS; i++) begin : g_slot
    assign is_roll[i] = (slots[i] == KC_ROLLOVER);
    assign is_key[i]  = (slots[i] != KC_NONE);
  end

  always_comb begin
    key  = KC_NONE;
    roll = |is_roll;
    // Scan high to low so the lowest nonzero slot is the final assignment
    if (!roll) begin
      for (int i = NKEYS - 1; i >= 0; i--) begin
        if (is_key[i]) key = slots[i];
      end
    end
  end

endmodule

// File: rtl/hid_keycode_source.sv
// Parses HID boot-keyboard reports and presents one keycode, updated only on frame strobes.
// Optional KEY_TIMEOUT_EN: release a stale key after TIMEOUT_FRAMES idle frames.
module hid_keycode_source
  import hid_pkg::*;
#(
  parameter int NKEYS          = 6,
  parameter int TIMEOUT_FRAMES = 30
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 frame_clk_rising_edge,
  hid_keycode_source_if.slave  rpt,
  output logic [7:0]           keycode,
  output logic [7:0]           modifier,
  output logic                 rollover_err,
  output logic [7:0]           drop_cnt
);

  localparam int CW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(NKEYS - 1);

  state_t                  state;
  logic                    ready;
  logic [CW-1:0]           cnt;
  logic [7:0]              shadow_mod;
  logic [NKEYS-1:0][7:0]   slots;
  logic [7:0]              pend_key;
  logic [7:0]              pend_mod;
  logic                    pend_roll;
  logic                    pend_vld;
  logic [7:0]              sel_key;
  logic                    sel_roll;
  logic                    accept;

`ifdef KEY_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_FRAMES);
  logic [7:0] fcnt;
`endif

  assign rpt.rpt_ready = ready;
  assign accept        = rpt.rpt_valid && ready;

  hid_key_select #(.NKEYS(NKEYS)) u_sel (
    .slots (slots),
    .key   (sel_key),
    .roll  (sel_roll)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= ST_MOD;
      ready        <= 1'b1;
      cnt          <= '0;
      shadow_mod   <= '0;
      slots        <= '0;
      pend_key     <= '0;
      pend_mod     <= '0;
      pend_roll    <= 1'b0;
      pend_vld     <= 1'b0;
      keycode      <= KC_NONE;
      modifier     <= '0;
      rollover_err <= 1'b0;
      drop_cnt     <= '0;
`ifdef KEY_TIMEOUT_EN
      fcnt         <= '0;
`endif
    end else begin
      // Frame apply reads the old pending value; a same-cycle COMMIT below re-arms pending
      if (frame_clk_rising_edge && pend_vld) begin
        keycode      <= pend_key;
        modifier     <= pend_mod;
        rollover_err <= pend_roll;
        pend_vld     <= 1'b0;
      end
`ifdef KEY_TIMEOUT_EN
      if (frame_clk_rising_edge) begin
        if (pend_vld) begin
          fcnt <= '0;
        end else if (fcnt < TO_LIM) begin
          fcnt <= fcnt + 8'd1;
          if (fcnt + 8'd1 == TO_LIM) begin
            keycode      <= KC_NONE;
            rollover_err <= 1'b0;
          end
        end
      end
`endif
      case (state)
        ST_MOD: if (accept) begin
          shadow_mod <= rpt.rpt_data;
          if (rpt.rpt_last) drop_cnt <= sat_inc8(drop_cnt);
          else              state    <= ST_RSV;
        end
        ST_RSV: if (accept) begin
          cnt <= '0;
          if (rpt.rpt_last) begin
            drop_cnt <= sat_inc8(drop_cnt);
            state    <= ST_MOD;
          end else begin
            state <= ST_KEYS;
          end
        end
        ST_KEYS: if (accept) begin
          slots[cnt] <= rpt.rpt_data;
          if (cnt == LAST_SLOT) begin
            if (rpt.rpt_last) begin
              state <= ST_COMMIT;
              ready <= 1'b0;
            end else begin
              drop_cnt <= sat_inc8(drop_cnt);
              state    <= ST_DRAIN;
            end
          end else if (rpt.rpt_last) begin
            drop_cnt <= sat_inc8(drop_cnt);
            state    <= ST_MOD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRAIN: if (accept && rpt.rpt_last) state <= ST_MOD;
        ST_COMMIT: begin
          pend_key  <= sel_key;
          pend_mod  <= shadow_mod;
          pend_roll <= sel_roll;
          pend_vld  <= 1'b1;
          state     <= ST_MOD;
          ready     <= 1'b1;
        end
        default: begin
          state <= ST_MOD;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
